led_blink_sched: RTL

LED_BLINK_SCHED -- requirements
Module: led_blink_sched

---
 rtl/led_blink_sched_pkg.sv | 19 +
 rtl/sw_debounce.sv | 35 +++
 rtl/led_blink_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/led_blink_sched_pkg.sv
// Shared types and width helpers for the LED blink scheduler.
package led_blink_sched_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  // Bits needed to hold a countdown that starts at max(on, off, gap) - 1.
  function automatic int timer_w(input int on_c, input int off_c, input int gap_c);
    int m;
    m = on_c;
    if (off_c > m) m = off_c;
    if (gap_c > m) m = gap_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int blink_w(input int n_req);
    return $clog2(n_req + 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// 2-flop synchronizer plus counting debouncer for one raw switch.
module sw_debounce #(
  parameter int DB_LEN = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db
);

  localparam int CW = $clog2(DB_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], sw};
      // Any cycle agreeing with the stable level restarts the run.
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_LEN - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin scheduler: requester w blinks the shared LED w+1 times, then a dark gap.
module led_blink_sched
  import led_blink_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DB_LEN  = 19,
  parameter int ON_CYC  = 12500000,
  parameter int OFF_CYC = 12500000,
  parameter int GAP_CYC = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           sw,
  output logic                       ld,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [N_REQ-1:0]           pend
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = timer_w(ON_CYC, OFF_CYC, GAP_CYC);
  localparam int BW = blink_w(N_REQ);

  logic [N_REQ-1:0] db, db_q, rise, pend_clr;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_db
      sw_debounce #(.DB_LEN(DB_LEN)) u_db (
        .clk (clk),
        .rst (rst),
        .sw  (sw[g]),
        .db  (db[g])
      );
    end
  endgenerate

  assign rise = db & ~db_q;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [BW-1:0]   blink_left, blink_n;
  logic [GW-1:0]   grant_n, winner, cand;
  logic            found, ld_n;

  // Round-robin search starting just above the last grant.
  always_comb begin
    winner = grant_id;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(grant_id) + k) % N_REQ);
      if (!found && pend[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    blink_n  = blink_left;
    grant_n  = grant_id;
    pend_clr = '0;
    case (state)
      IDLE: if (found) begin
        grant_n          = winner;
        pend_clr[winner] = 1'b1;
        blink_n          = BW'(winner) + BW'(1);
        timer_n          = TW'(ON_CYC - 1);
        state_n          = ON;
      end
      ON: if (timer == '0) begin
        timer_n = TW'(OFF_CYC - 1);
        blink_n = blink_left - BW'(1);
        state_n = OFF;
      end else begin
        timer_n = timer - TW'(1);
      end
      OFF: if (timer == '0) begin
        if (blink_left != '0) begin
          timer_n = TW'(ON_CYC - 1);
          state_n = ON;
        end else begin
          timer_n = TW'(GAP_CYC - 1);
          state_n = GAP;
        end
      end else begin
        timer_n = timer - TW'(1);
      end
      GAP: if (timer == '0) begin
        state_n = IDLE;
      end else begin
        timer_n = timer - TW'(1);
      end
      default: state_n = IDLE;
    endcase
    ld_n = (state_n == ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      blink_left <= '0;
      ld         <= 1'b0;
      grant_id   <= GW'(N_REQ - 1);
      pend       <= '0;
      db_q       <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      blink_left <= blink_n;
      ld         <= ld_n;
      grant_id   <= grant_n;
      db_q       <= db;
      // A new rise wins over the grant's clear so the request is not lost.
      pend       <= (pend & ~pend_clr) | rise;
    end
  end

  assign busy = (state != IDLE);

endmodule
